bmp_stream_parser: RTL and testbench
====================================

Name: bmp_stream_parser

Overview:
- Sequences a raw BMP byte stream (file image, byte 0 first) into a 24-bit pixel stream.
- Parses the 54-byte header and exposes width, height, pixel-data offset and file size.
- Skips to the pixel data, strips 4-byte row padding, and tags each pixel with coordinates and frame markers.
- Sits between the byte source (file loader / memory reader) and downstream image-processing blocks.

Parameters:
- DIM_W, 16, width of the pix_x/pix_y and hdr_width/hdr_height outputs; header width/height must fit in DIM_W bits.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin parsing a new file; honoured only in IDLE, DONE or ERROR
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- pix_rgb  out  24  {R,G,B}
- pix_valid  out  1  pixel valid; held with stable data until pix_ready
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  DIM_W  column of current pixel
- pix_y  out  DIM_W  row in file order (0 = first stored row)
- sof, eol, eof  out  1 each  first pixel of frame / last pixel of row / last pixel of frame; qualified by pix_valid
- hdr_width, hdr_height  out  DIM_W  parsed dimensions
- hdr_offset, hdr_size  out  32  pixel-data offset, file size
- hdr_valid  out  1  header fields valid
- busy  out  1  state is HEADER, SKIP, PIXEL or PAD
- err  out  1  sticky header error

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0. Reset mid-frame discards all partial state.
- States: IDLE, HEADER, SKIP, PIXEL, PAD, DONE, ERROR.
- in_ready: 0 in IDLE/DONE/ERROR; 1 in HEADER/SKIP/PAD; in PIXEL equals (!pix_valid || pix_ready).
- Byte counter: 32 bits, incremented on every accepted byte; cleared on start.
- start:
  - IDLE/DONE/ERROR -> HEADER; clears err, hdr_valid, counters.
  - Ignored in all other states.
- HEADER:
  - Little-endian fields latched: size = bytes 2-5, offset = 10-13, width = 18-21, height = 22-25, bpp = 28-29.
  - Byte 0 != 0x42 or byte 1 != 0x4D -> ERROR on that byte.
  - After byte 53, go to ERROR if any of: bpp != 24; width or height = 0; width/height upper bits beyond DIM_W nonzero (covers negative height); offset < 54.
  - Otherwise hdr_valid = 1 on the next cycle and stays 1 until start/rst. Next state SKIP if offset > 54, else PIXEL.
- SKIP: discard bytes until counter == offset, then PIXEL.
- PIXEL:
  - Bytes arrive B, G, R. On R accepted, pix_rgb = {R,G,B} and pix_valid = 1 the next cycle (latency 1).
  - pix_valid clears on pix_ready when no new pixel is loaded.
  - One-deep output register; back-to-back transfer allowed when pix_ready = 1.
- Coordinates:
  - pix_x increments per pixel.
  - At x = width-1: eol = 1, x wraps to 0, y increments.
  - pad = (4 - (3*width mod 4)) mod 4. If pad > 0 -> PAD, else stay in PIXEL.
- PAD: discard pad bytes, then PIXEL, or DONE if the last row is finished.
- Frame markers:
  - sof = 1 for (x=0, y=0).
  - eof = 1 for (x = width-1, y = height-1).
  - Last row with pad = 0: DONE after the eof pixel is accepted. With pad > 0: DONE after the pad bytes.
- DONE: in_ready = 0; header outputs hold; bytes beyond the computed frame length (including trailing bytes implied by hdr_size) are not consumed.
- ERROR: err = 1; in_ready = 0; pix_valid = 0. No further pixels until start.
- in_valid gaps in any state: counters and the partial pixel hold.

Test Plan:
- 2x2 image, offset 54, size 70, pixels (B,G,R) 01 02 03 / 04 05 06 / pad 00 00 per row -> 4 pixels: pix_rgb 0x030201 sof (0,0); 0x060504 eol (1,0); ... last with eof (1,1); DONE; 70 bytes consumed.
- Width 4, height 1 (pad 0), offset 54 -> 4 pixels, eol+eof on x=3, no PAD state entered.
- Offset 58 with 4 filler bytes 0xAA -> filler never appears on pix_rgb; first pixel matches byte 58-60; hdr_offset = 58.
- Bytes 0,1 = 0x42,0x4E -> err = 1 the cycle after byte 1; in_ready = 0; no pix_valid. start -> err = 0, parse restarts.
- bpp = 32 -> ERROR after byte 53; hdr_valid stays 0.
- 2x2 image with pix_ready low for 5 cycles on the first pixel -> pix_rgb stable, in_ready = 0 during the stall, no pixel lost or duplicated.
- rst during PIXEL -> all outputs 0, state IDLE; next start parses a fresh file correctly.

Source files
------------

// File: rtl/bmp_stream_parser.sv
// bmp_stream_parser
//   Turns a raw BMP file image (byte 0 first) into a stream of 24-bit pixels.
//   The 54-byte header is parsed and checked, any gap up to the pixel data is
//   skipped, row padding is stripped and every pixel is tagged with its
//   coordinates and frame markers.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               begin a new file (honoured in IDLE, DONE, ERROR)
//   in_data/in_valid/in_ready     byte input stream
//   pix_rgb/pix_valid/pix_ready   {R,G,B} pixel output stream
//   pix_x, pix_y        column / file-order row of the presented pixel
//   sof, eol, eof       frame / row markers, qualified by pix_valid
//   hdr_*               parsed header fields, hdr_valid once checked
//   busy, err           parser activity, sticky header error
//   dbg_state           current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A valid source holds its data stable until that edge; ready may
// depend combinationally on valid but valid never waits on ready.
module bmp_stream_parser #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [23:0]      pix_rgb,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [DIM_W-1:0] pix_x,
  output logic [DIM_W-1:0] pix_y,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic [DIM_W-1:0] hdr_width,
  output logic [DIM_W-1:0] hdr_height,
  output logic [31:0]      hdr_offset,
  output logic [31:0]      hdr_size,
  output logic             hdr_valid,
  output logic             busy,
  output logic             err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_SKIP   = 3'd2,
    S_PIXEL  = 3'd3,
    S_PAD    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      size_q, size_d;
  logic [31:0]      offset_q, offset_d;
  logic [31:0]      width_q, width_d;
  logic [31:0]      height_q, height_d;
  logic [15:0]      bpp_q, bpp_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic             err_q, err_d;
  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       g_q, g_d;
  logic [1:0]       pad_cnt_q, pad_cnt_d;
  logic             last_row_q, last_row_d;
  logic [23:0]      pix_rgb_q, pix_rgb_d;
  logic             pix_valid_q, pix_valid_d;
  logic [DIM_W-1:0] pix_x_q, pix_x_d;
  logic [DIM_W-1:0] pix_y_q, pix_y_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             eof_q, eof_d;

  logic             in_ready_c;
  logic             accept;
  logic [DIM_W-1:0] w_last;
  logic [DIM_W-1:0] h_last;
  logic             at_eol;
  logic [3:0]       w3;
  logic [1:0]       pad_len;
  logic             hdr_bad;

  assign w_last  = width_q[DIM_W-1:0] - DIM_W'(1);
  assign h_last  = height_q[DIM_W-1:0] - DIM_W'(1);
  assign at_eol  = (x_q == w_last);
  // Row padding only depends on 3*width mod 4, i.e. on width[1:0].
  assign w3      = 4'(width_q[1:0]) * 4'd3;
  assign pad_len = 2'(4'd4 - {2'b00, w3[1:0]});
  // Upper-bit check also rejects negative (top-down) heights.
  assign hdr_bad = (bpp_q != 16'd24) || (width_q == 32'd0) || (height_q == 32'd0) ||
                   ((width_q >> DIM_W) != 32'd0) || ((height_q >> DIM_W) != 32'd0) ||
                   (offset_q < 32'd54);

  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      S_HEADER, S_SKIP, S_PAD: in_ready_c = 1'b1;
      S_PIXEL:                 in_ready_c = !pix_valid_q || pix_ready;
      default:                 in_ready_c = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    offset_d    = offset_q;
    width_d     = width_q;
    height_d    = height_q;
    bpp_d       = bpp_q;
    hdr_valid_d = hdr_valid_q;
    err_d       = err_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    b_d         = b_q;
    g_d         = g_q;
    pad_cnt_d   = pad_cnt_q;
    last_row_d  = last_row_q;
    pix_rgb_d   = pix_rgb_q;
    pix_valid_d = pix_valid_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
    eof_d       = eof_q;

    if (accept) cnt_d = cnt_q + 32'd1;

    // Output register drains independently of the parser state; a new
    // pixel loaded below in the same cycle takes priority.
    if (pix_valid_q && pix_ready) begin
      pix_valid_d = 1'b0;
      sof_d       = 1'b0;
      eol_d       = 1'b0;
      eof_d       = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_HEADER;
          cnt_d       = 32'd0;
          err_d       = 1'b0;
          hdr_valid_d = 1'b0;
          x_d         = '0;
          y_d         = '0;
          phase_d     = 2'd0;
          pad_cnt_d   = 2'd0;
          last_row_d  = 1'b0;
        end
      end
      S_HEADER: begin
        if (accept) begin
          case (cnt_q)
            32'd0:  if (in_data != 8'h42) state_d = S_ERROR;
            32'd1:  if (in_data != 8'h4D) state_d = S_ERROR;
            32'd2:  size_d[7:0]     = in_data;
            32'd3:  size_d[15:8]    = in_data;
            32'd4:  size_d[23:16]   = in_data;
            32'd5:  size_d[31:24]   = in_data;
            32'd10: offset_d[7:0]   = in_data;
            32'd11: offset_d[15:8]  = in_data;
            32'd12: offset_d[23:16] = in_data;
            32'd13: offset_d[31:24] = in_data;
            32'd18: width_d[7:0]    = in_data;
            32'd19: width_d[15:8]   = in_data;
            32'd20: width_d[23:16]  = in_data;
            32'd21: width_d[31:24]  = in_data;
            32'd22: height_d[7:0]   = in_data;
            32'd23: height_d[15:8]  = in_data;
            32'd24: height_d[23:16] = in_data;
            32'd25: height_d[31:24] = in_data;
            32'd28: bpp_d[7:0]      = in_data;
            32'd29: bpp_d[15:8]     = in_data;
            32'd53: begin
              // All checked fields were latched by byte 29.
              if (hdr_bad) begin
                state_d = S_ERROR;
              end else begin
                hdr_valid_d = 1'b1;
                state_d     = (offset_q > 32'd54) ? S_SKIP : S_PIXEL;
              end
            end
            default: ;
          endcase
        end
      end
      S_SKIP: begin
        if (accept && (cnt_q + 32'd1 == offset_q)) state_d = S_PIXEL;
      end
      S_PIXEL: begin
        if (accept) begin
          case (phase_q)
            2'd0: begin
              b_d     = in_data;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = in_data;
              phase_d = 2'd2;
            end
            default: begin
              phase_d     = 2'd0;
              pix_rgb_d   = {in_data, g_q, b_q};
              pix_valid_d = 1'b1;
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              sof_d       = (x_q == '0) && (y_q == '0);
              eol_d       = at_eol;
              eof_d       = at_eol && (y_q == h_last);
              if (at_eol) begin
                x_d = '0;
                y_d = y_q + DIM_W'(1);
                if (pad_len != 2'd0) begin
                  state_d    = S_PAD;
                  pad_cnt_d  = 2'd0;
                  last_row_d = (y_q == h_last);
                end else if (y_q == h_last) begin
                  state_d = S_DONE;
                end
              end else begin
                x_d = x_q + DIM_W'(1);
              end
            end
          endcase
        end
      end
      S_PAD: begin
        if (accept) begin
          pad_cnt_d = pad_cnt_q + 2'd1;
          if (pad_cnt_q == pad_len - 2'd1) state_d = last_row_q ? S_DONE : S_PIXEL;
        end
      end
      default: ;
    endcase

    if (state_d == S_ERROR) begin
      err_d       = 1'b1;
      pix_valid_d = 1'b0;
      sof_d       = 1'b0;
      eol_d       = 1'b0;
      eof_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      size_q      <= 32'd0;
      offset_q    <= 32'd0;
      width_q     <= 32'd0;
      height_q    <= 32'd0;
      bpp_q       <= 16'd0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 2'd0;
      b_q         <= 8'd0;
      g_q         <= 8'd0;
      pad_cnt_q   <= 2'd0;
      last_row_q  <= 1'b0;
      pix_rgb_q   <= 24'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      offset_q    <= offset_d;
      width_q     <= width_d;
      height_q    <= height_d;
      bpp_q       <= bpp_d;
      hdr_valid_q <= hdr_valid_d;
      err_q       <= err_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      b_q         <= b_d;
      g_q         <= g_d;
      pad_cnt_q   <= pad_cnt_d;
      last_row_q  <= last_row_d;
      pix_rgb_q   <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign pix_rgb    = pix_rgb_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign eof        = eof_q;
  assign hdr_width  = width_q[DIM_W-1:0];
  assign hdr_height = height_q[DIM_W-1:0];
  assign hdr_offset = offset_q;
  assign hdr_size   = size_q;
  assign hdr_valid  = hdr_valid_q;
  assign err        = err_q;
  assign busy       = (state_q == S_HEADER) || (state_q == S_SKIP) ||
                      (state_q == S_PIXEL)  || (state_q == S_PAD);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Testbench for bmp_stream_parser: directed BMP file images, pixel
// scoreboard, per-scenario tasks and one summary line.
module tb_bmp_stream_parser;
  localparam int DIM_W = 16;
  localparam int W     = 3 + 2 * DIM_W + 24;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HEADER = 3'd1;
  localparam logic [2:0] ST_PIXEL  = 3'd3;
  localparam logic [2:0] ST_PAD    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [23:0]      pix_rgb;
  logic             pix_valid;
  logic             pix_ready = 1'b1;
  logic [DIM_W-1:0] pix_x, pix_y;
  logic             sof, eol, eof;
  logic [DIM_W-1:0] hdr_width, hdr_height;
  logic [31:0]      hdr_offset, hdr_size;
  logic             hdr_valid, busy, err;
  logic [2:0]       dbg_state;

  bmp_stream_parser #(.DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .eof(eof),
    .hdr_width(hdr_width), .hdr_height(hdr_height),
    .hdr_offset(hdr_offset), .hdr_size(hdr_size), .hdr_valid(hdr_valid),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int acc      = 0;
  int exp_size = 0;
  bit saw_pad  = 1'b0;

  logic [7:0]   file_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rcv_q[$];

  // Scoreboard capture: every pixel handshake, packed {sof,eol,eof,x,y,rgb}.
  always @(posedge clk) begin
    if (!rst && pix_valid && pix_ready) rcv_q.push_back({sof, eol, eof, pix_x, pix_y, pix_rgb});
    if (dbg_state == ST_PAD) saw_pad = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Builds a file image and the expected pixel list. Pixel k carries
  // B=3k+1, G=3k+2, R=3k+3; filler bytes before the pixel data are 0xAA.
  task automatic make_file(input int w, input int h, input int off, input int bpp,
                           input logic [7:0] magic1);
    int pad, k, total;
    logic [31:0] v;
    pad   = (4 - ((3 * w) % 4)) % 4;
    total = off + h * (3 * w + pad);
    exp_size = total;
    file_q.delete();
    exp_q.delete();
    for (int i = 0; i < 54; i++) file_q.push_back(8'h00);
    file_q[0] = 8'h42;
    file_q[1] = magic1;
    v = total; for (int i = 0; i < 4; i++) file_q[2 + i]  = v[8*i +: 8];
    v = off;   for (int i = 0; i < 4; i++) file_q[10 + i] = v[8*i +: 8];
    file_q[14] = 8'd40;
    v = w;     for (int i = 0; i < 4; i++) file_q[18 + i] = v[8*i +: 8];
    v = h;     for (int i = 0; i < 4; i++) file_q[22 + i] = v[8*i +: 8];
    file_q[26] = 8'd1;
    v = bpp;   file_q[28] = v[7:0]; file_q[29] = v[15:8];
    for (int i = 54; i < off; i++) file_q.push_back(8'hAA);
    k = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        logic [7:0] b, g, r;
        logic [DIM_W-1:0] xx, yy;
        b = 8'(3 * k + 1); g = 8'(3 * k + 2); r = 8'(3 * k + 3);
        xx = DIM_W'(x); yy = DIM_W'(y);
        file_q.push_back(b); file_q.push_back(g); file_q.push_back(r);
        exp_q.push_back({(x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1),
                         xx, yy, r, g, b});
        k++;
      end
      for (int p = 0; p < pad; p++) file_q.push_back(8'h00);
    end
  endtask

  // Driver: offers file_q bytes in order; stops at the first byte that is
  // not accepted within 60 cycles. Returns the number of accepted bytes.
  task automatic send_file(output int acc_o);
    int a;
    bit stop;
    a = 0;
    stop = 1'b0;
    for (int i = 0; i < file_q.size() && !stop; i++) begin
      bit ok;
      ok = 1'b0;
      in_data  = file_q[i];
      in_valid = 1'b1;
      for (int c = 0; c < 60 && !ok; c++) begin
        @(posedge clk);
        if (in_ready) ok = 1'b1;
      end
      #1;
      if (ok) a++;
      else stop = 1'b1;
    end
    in_valid = 1'b0;
    acc_o = a;
  endtask

  task automatic apply_reset;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drain;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    n_checks++; if (pix_rgb !== 24'd0) begin n_fail++; $display("FAIL reset_pix_rgb: got %h want 0", pix_rgb); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if ({hdr_valid, err, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {hdr_valid, err, busy}); end
    n_checks++; if ({sof, eol, eof} !== 3'b000) begin n_fail++; $display("FAIL reset_markers: got %b want 000", {sof, eol, eof}); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_basic_2x2;
    make_file(2, 2, 54, 24, 8'h4D);
    file_q.push_back(8'hEE); file_q.push_back(8'hEE);
    rcv_q.delete();
    pulse_start;
    n_checks++; if (dbg_state !== ST_HEADER || busy !== 1'b1) begin n_fail++; $display("FAIL start_header: state %0d busy %b want %0d 1", dbg_state, busy, ST_HEADER); end
    send_file(acc);
    drain;
    n_checks++; if (acc !== 70) begin n_fail++; $display("FAIL b2x2_consumed: got %0d want 70", acc); end
    n_checks++; if (hdr_width !== 16'd2 || hdr_height !== 16'd2) begin n_fail++; $display("FAIL b2x2_dims: got %0d x %0d want 2 x 2", hdr_width, hdr_height); end
    n_checks++; if (hdr_offset !== 32'd54 || hdr_size !== 32'd70) begin n_fail++; $display("FAIL b2x2_hdr: off %0d size %0d want 54 70", hdr_offset, hdr_size); end
    n_checks++; if (hdr_valid !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL b2x2_valid: hv %b err %b want 1 0", hdr_valid, err); end
    n_checks++; if (dbg_state !== ST_DONE || in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2x2_done: state %0d rdy %b busy %b", dbg_state, in_ready, busy); end
    n_checks++; if (rcv_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2x2_count: got %0d want %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      n_checks++; if (rcv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2x2_pix%0d: got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_no_pad_w4h1;
    make_file(4, 1, 54, 24, 8'h4D);
    file_q.push_back(8'hEE);
    rcv_q.delete();
    pulse_start;
    saw_pad = 1'b0;
    send_file(acc);
    drain;
    n_checks++; if (acc !== 66) begin n_fail++; $display("FAIL w4_consumed: got %0d want 66", acc); end
    n_checks++; if (saw_pad !== 1'b0) begin n_fail++; $display("FAIL w4_pad_entered: got %b want 0", saw_pad); end
    n_checks++; if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL w4_done: got %0d want %0d", dbg_state, ST_DONE); end
    n_checks++; if (rcv_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL w4_count: got %0d want %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      n_checks++; if (rcv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL w4_pix%0d: got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_skip_offset58;
    make_file(2, 2, 58, 24, 8'h4D);
    rcv_q.delete();
    pulse_start;
    send_file(acc);
    drain;
    n_checks++; if (acc !== exp_size) begin n_fail++; $display("FAIL skip_consumed: got %0d want %0d", acc, exp_size); end
    n_checks++; if (hdr_offset !== 32'd58) begin n_fail++; $display("FAIL skip_offset: got %0d want 58", hdr_offset); end
    n_checks++; if (rcv_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL skip_count: got %0d want %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      n_checks++; if (rcv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL skip_pix%0d: got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_magic;
    make_file(4, 1, 54, 24, 8'h4E);
    while (file_q.size() > 2) void'(file_q.pop_back());
    rcv_q.delete();
    pulse_start;
    send_file(acc);
    // Driver returns #1 after the edge that accepted byte 1.
    n_checks++; if (err !== 1'b1 || dbg_state !== ST_ERROR) begin n_fail++; $display("FAIL magic_err: err %b state %0d want 1 %0d", err, dbg_state, ST_ERROR); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL magic_in_ready: got %b want 0", in_ready); end
    make_file(4, 1, 54, 24, 8'h4D);
    send_file(acc);
    n_checks++; if (acc !== 0) begin n_fail++; $display("FAIL magic_consumed: got %0d want 0", acc); end
    n_checks++; if (rcv_q.size() !== 0 || pix_valid !== 1'b0) begin n_fail++; $display("FAIL magic_pixels: got %0d pixels valid %b want 0 0", rcv_q.size(), pix_valid); end
    pulse_start;
    n_checks++; if (err !== 1'b0 || dbg_state !== ST_HEADER) begin n_fail++; $display("FAIL magic_restart: err %b state %0d want 0 %0d", err, dbg_state, ST_HEADER); end
    send_file(acc);
    drain;
    n_checks++; if (rcv_q.size() !== 4 || dbg_state !== ST_DONE) begin n_fail++; $display("FAIL magic_reparse: got %0d pixels state %0d want 4 %0d", rcv_q.size(), dbg_state, ST_DONE); end
  endtask

  task automatic test_bad_bpp;
    make_file(2, 2, 54, 32, 8'h4D);
    rcv_q.delete();
    pulse_start;
    send_file(acc);
    n_checks++; if (acc !== 54) begin n_fail++; $display("FAIL bpp_consumed: got %0d want 54", acc); end
    n_checks++; if (err !== 1'b1 || dbg_state !== ST_ERROR) begin n_fail++; $display("FAIL bpp_err: err %b state %0d want 1 %0d", err, dbg_state, ST_ERROR); end
    n_checks++; if (hdr_valid !== 1'b0) begin n_fail++; $display("FAIL bpp_hdr_valid: got %b want 0", hdr_valid); end
    n_checks++; if (rcv_q.size() !== 0) begin n_fail++; $display("FAIL bpp_pixels: got %0d want 0", rcv_q.size()); end
  endtask

  task automatic test_back_to_back_stall;
    make_file(2, 2, 54, 24, 8'h4D);
    rcv_q.delete();
    pulse_start;
    pix_ready = 1'b0;
    fork
      send_file(acc);
      begin
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
          @(negedge clk);
          if (pix_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stall_first_pixel: got %b want 1", seen); end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_checks++; if (pix_valid !== 1'b1 || pix_rgb !== 24'h030201) begin n_fail++; $display("FAIL stall_hold%0d: valid %b rgb %h want 1 030201", k, pix_valid, pix_rgb); end
          n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready%0d: got %b want 0", k, in_ready); end
        end
        pix_ready = 1'b1;
      end
    join
    drain;
    n_checks++; if (acc !== 70) begin n_fail++; $display("FAIL stall_consumed: got %0d want 70", acc); end
    n_checks++; if (rcv_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      n_checks++; if (rcv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_pix%0d: got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    make_file(2, 2, 54, 24, 8'h4D);
    while (file_q.size() > 58) void'(file_q.pop_back());
    pulse_start;
    send_file(acc);
    n_checks++; if (dbg_state !== ST_PIXEL || hdr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_state: state %0d hv %b want %0d 1", dbg_state, hdr_valid, ST_PIXEL); end
    apply_reset;
    n_checks++; if (dbg_state !== ST_IDLE || {hdr_valid, err, busy, in_ready} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flags: state %0d flags %b want 0 0000", dbg_state, {hdr_valid, err, busy, in_ready}); end
    n_checks++; if (pix_valid !== 1'b0 || pix_rgb !== 24'd0 || hdr_width !== 16'd0 || hdr_offset !== 32'd0) begin n_fail++; $display("FAIL mid_rst_outputs: valid %b rgb %h w %0d off %0d want 0", pix_valid, pix_rgb, hdr_width, hdr_offset); end
    make_file(2, 2, 54, 24, 8'h4D);
    rcv_q.delete();
    pulse_start;
    send_file(acc);
    drain;
    n_checks++; if (acc !== 70 || dbg_state !== ST_DONE) begin n_fail++; $display("FAIL mid_reparse: consumed %0d state %0d want 70 %0d", acc, dbg_state, ST_DONE); end
    n_checks++; if (rcv_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      n_checks++; if (rcv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_pix%0d: got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_basic_2x2;
    test_no_pad_w4h1;
    test_skip_offset58;
    test_bad_magic;
    test_bad_bpp;
    test_back_to_back_stall;
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
